uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmitter fed by a multi-byte-per-cycle circular FIFO.
// Frames are start, DATA_BITS LSB-first, optional parity, then STOP_BITS stop bits.
module uart_tx_framer #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUDRATE  = 115200,
   parameter int DEPTH     = 8,
   parameter int N         = 8,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0][7:0]          data_i,
   input  logic [$clog2(N+1)-1:0]     push,
   output logic [$clog2(N+1)-1:0]     can_push,
   output logic                       overflow,
   output logic                       busy,
   output logic                       tx
);
   localparam int DIV = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
   localparam int PUW = $clog2(N + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [7:0] DMASK = 8'((16'd1 << DATA_BITS) - 16'd1);

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx_framer: bit period shorter than 2 clk cycles");
   end
   if (N < 1 || N > DEPTH || DATA_BITS < 5 || DATA_BITS > 8 ||
       PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_par_chk
      $error("uart_tx_framer: parameter out of range");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   function automatic logic parity_bit(input logic [7:0] b);
      return (PARITY == 1) ? ~^b : ^b;
   endfunction

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, free_s;
   logic [PUW-1:0] can_push_s;
   logic          accept_s, pop_s, bit_end_s;
   logic [PW:0]   wr_sum_s [N];
   logic [PW-1:0] wr_idx_s [N];
   logic [PW:0]   wr_adv_s;
   logic [7:0]    head_s;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d, tx_q, tx_d, busy_q, overflow_q;

   // Occupancy, free space and write addressing (pointers wrap modulo DEPTH)
   always_comb begin
      free_s   = CW'(DEPTH) - count_q;
      can_push_s = (free_s > CW'(N)) ? PUW'(N) : PUW'(free_s);
      accept_s = (push != '0) && (push <= can_push_s);
      for (int i = 0; i < N; i++) begin
         wr_sum_s[i] = {1'b0, wr_ptr_q} + (PW+1)'(i);
         if (wr_sum_s[i] >= (PW+1)'(DEPTH)) begin
            wr_idx_s[i] = PW'(wr_sum_s[i] - (PW+1)'(DEPTH));
         end else begin
            wr_idx_s[i] = wr_sum_s[i][PW-1:0];
         end
      end
      wr_adv_s = {1'b0, wr_ptr_q} + (PW+1)'(push);
      if (!accept_s) begin
         wr_ptr_d = wr_ptr_q;
      end else if (wr_adv_s >= (PW+1)'(DEPTH)) begin
         wr_ptr_d = PW'(wr_adv_s - (PW+1)'(DEPTH));
      end else begin
         wr_ptr_d = wr_adv_s[PW-1:0];
      end
      if (!pop_s) begin
         rd_ptr_d = rd_ptr_q;
      end else if (rd_ptr_q == PW'(DEPTH - 1)) begin
         rd_ptr_d = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (accept_s ? CW'(push) : CW'(0)) - CW'(pop_s);
      head_s  = mem_q[rd_ptr_q] & DMASK;
   end

   // Framer next state; every bit lasts DIV cycles and the baud counter restarts per bit
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      pop_s     = 1'b0;
      bit_end_s = (baud_q == BW'(DIV - 1));
      if (state_q != S_IDLE) begin
         baud_d = bit_end_s ? BW'(0) : baud_q + BW'(1);
      end else begin
         baud_d = BW'(0);
      end
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop_s   = 1'b1;
               state_d = S_START;
               tx_d    = 1'b0;
               shift_d = head_s;
               par_d   = parity_bit(head_s);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = 3'd0;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (!bit_end_s) begin
               state_d = S_DATA;
            end else if (bit_q != 3'(DATA_BITS - 1)) begin
               bit_d   = bit_q + 3'd1;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end else if (PARITY != 0) begin
               state_d = S_PAR;
               tx_d    = par_q;
            end else begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               bit_d   = 3'd0;
            end
         end
         S_PAR: begin
            if (bit_end_s) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               bit_d   = 3'd0;
            end else begin
               state_d = S_PAR;
            end
         end
         S_STOP: begin
            if (!bit_end_s) begin
               state_d = S_STOP;
            end else if (bit_q != 3'(STOP_BITS - 1)) begin
               bit_d = bit_q + 3'd1;
            end else if (count_q != '0) begin
               pop_s   = 1'b1;
               state_d = S_START;
               tx_d    = 1'b0;
               shift_d = head_s;
               par_d   = parity_bit(head_s);
            end else begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // FIFO storage and pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (accept_s && (PUW'(i) < push)) mem_q[wr_idx_s[i]] <= data_i[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Framer registers; tx resets high asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         busy_q     <= (state_d != S_IDLE);
         overflow_q <= (push > can_push_s);
      end
   end

   assign can_push = can_push_s;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign tx       = tx_q;
endmodule
